// File: rtl/lk_iter_ctrl_if.sv
// Signal bundle between the LK iteration controller, the b/G-inverse stage and the fetch stage.
// Latency: none, wires only.
// Backpressure: none; start, d_valid, b_reset, fetch_req and done are single-cycle pulses.
interface lk_iter_ctrl_if #(
    parameter int D_BITS    = 32,
    parameter int V_BITS    = 34,
    parameter int ITER_BITS = 4
);
    logic                 start;
    logic [V_BITS-1:0]    gr_in;
    logic [V_BITS-1:0]    gc_in;
    logic                 d_valid;
    logic [D_BITS-1:0]    dr;
    logic [D_BITS-1:0]    dc;
    logic                 valid_det;
    logic                 b_reset;
    logic                 fetch_req;
    logic [V_BITS-1:0]    vr;
    logic [V_BITS-1:0]    vc;
    logic [ITER_BITS-1:0] iter_count;
    logic                 busy;
    logic                 done;
    logic                 converged;
    logic                 stop;
    logic                 feature_loss;

    // Upstream / control side: issues start and increments, observes status.
    modport master (
        output start, gr_in, gc_in, d_valid, dr, dc, valid_det,
        input  b_reset, fetch_req, vr, vc, iter_count, busy, done,
               converged, stop, feature_loss
    );

    // Controller side.
    modport slave (
        input  start, gr_in, gc_in, d_valid, dr, dc, valid_det,
        output b_reset, fetch_req, vr, vc, iter_count, busy, done,
               converged, stop, feature_loss
    );
endinterface

// File: rtl/lk_iter_ctrl.sv
// LK iteration controller: accumulates per-pass displacement increments and decides when to stop.
// Latency: start->fetch_req 1 cycle; d_valid->next fetch_req 3 cycles; d_valid->done 3 (2 if det=0).
// Backpressure: none; waits indefinitely in WAIT_D for d_valid, ignores start while busy.
module lk_iter_ctrl #(
    parameter int D_BITS    = 32,
    parameter int D_FRAC    = 26,
    parameter int V_BITS    = 34,
    parameter int EPS       = 2**20,
    parameter int K_MAX     = 8,
    parameter int ITER_BITS = 4,
    parameter int V_LIMIT   = 15
) (
    input  logic           clk,
    input  logic           reset,
    lk_iter_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT_D = 3'd2,
        S_UPDATE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Thresholds held one bit wider than the operands so the magnitude of the
    // most negative value is representable and compares as large.
    localparam logic [V_BITS:0]    V_LIM_RAW = (V_BITS+1)'(V_LIMIT) << D_FRAC;
    localparam logic [D_BITS:0]    EPS_RAW   = (D_BITS+1)'(EPS);
    localparam logic [ITER_BITS-1:0] K_MAX_C = ITER_BITS'(K_MAX);

    state_t               state_q, state_d;
    logic [V_BITS-1:0]    vr_q, vc_q;
    logic [D_BITS-1:0]    dr_q, dc_q;
    logic [ITER_BITS-1:0] iter_q;
    logic                 conv_q, stop_q, loss_q;

    logic load_guess, latch_d, do_update, set_loss, set_conv, set_stop;
    logic b_reset_c, fetch_c, done_c, busy_c;

    logic [V_BITS:0] vr_x, vc_x, vr_mag, vc_mag;
    logic [D_BITS:0] dr_x, dc_x, dr_mag, dc_mag;
    logic            v_big, d_small;

    // Magnitudes of the running estimate and of the last increment.
    always_comb begin
        vr_x    = {vr_q[V_BITS-1], vr_q};
        vc_x    = {vc_q[V_BITS-1], vc_q};
        dr_x    = {dr_q[D_BITS-1], dr_q};
        dc_x    = {dc_q[D_BITS-1], dc_q};
        vr_mag  = vr_x[V_BITS] ? -vr_x : vr_x;
        vc_mag  = vc_x[V_BITS] ? -vc_x : vc_x;
        dr_mag  = dr_x[D_BITS] ? -dr_x : dr_x;
        dc_mag  = dc_x[D_BITS] ? -dc_x : dc_x;
        v_big   = (vr_mag > V_LIM_RAW) || (vc_mag > V_LIM_RAW);
        d_small = (dr_mag < EPS_RAW) && (dc_mag < EPS_RAW);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, pass strobes and datapath enables.
    always_comb begin
        state_d    = state_q;
        b_reset_c  = 1'b0;
        fetch_c    = 1'b0;
        done_c     = 1'b0;
        busy_c     = (state_q != S_IDLE);
        load_guess = 1'b0;
        latch_d    = 1'b0;
        do_update  = 1'b0;
        set_loss   = 1'b0;
        set_conv   = 1'b0;
        set_stop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load_guess = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                b_reset_c = 1'b1;
                fetch_c   = 1'b1;
                state_d   = S_WAIT_D;
            end
            S_WAIT_D: begin
                if (bus.d_valid) begin
                    if (!bus.valid_det) begin
                        // Singular G: the estimate is left untouched. The pass
                        // drains through CHECK so done lands 2 cycles later.
                        set_loss = 1'b1;
                        state_d  = S_CHECK;
                    end else begin
                        latch_d = 1'b1;
                        state_d = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                do_update = 1'b1;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (loss_q) begin
                    state_d = S_DONE;
                end else if (v_big) begin
                    set_loss = 1'b1;
                    state_d  = S_DONE;
                end else if (d_small) begin
                    set_conv = 1'b1;
                    state_d  = S_DONE;
                end else if (iter_q == K_MAX_C) begin
                    set_stop = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Displacement estimate, latched increment, iteration count and sticky status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vr_q   <= '0;
            vc_q   <= '0;
            dr_q   <= '0;
            dc_q   <= '0;
            iter_q <= '0;
            conv_q <= 1'b0;
            stop_q <= 1'b0;
            loss_q <= 1'b0;
        end else begin
            if (load_guess) begin
                vr_q   <= bus.gr_in;
                vc_q   <= bus.gc_in;
                iter_q <= '0;
                conv_q <= 1'b0;
                stop_q <= 1'b0;
                loss_q <= 1'b0;
            end
            if (latch_d) begin
                dr_q <= bus.dr;
                dc_q <= bus.dc;
            end
            if (do_update) begin
                // Headroom in V_BITS covers the worst case reachable before the
                // V_LIMIT check ends the feature, so no saturation.
                vr_q   <= vr_q + {{(V_BITS-D_BITS){dr_q[D_BITS-1]}}, dr_q};
                vc_q   <= vc_q + {{(V_BITS-D_BITS){dc_q[D_BITS-1]}}, dc_q};
                iter_q <= iter_q + ITER_BITS'(1);
            end
            if (set_loss) loss_q <= 1'b1;
            if (set_conv) conv_q <= 1'b1;
            if (set_stop) stop_q <= 1'b1;
        end
    end

    assign bus.b_reset      = b_reset_c;
    assign bus.fetch_req    = fetch_c;
    assign bus.done         = done_c;
    assign bus.busy         = busy_c;
    assign bus.vr           = vr_q;
    assign bus.vc           = vc_q;
    assign bus.iter_count   = iter_q;
    assign bus.converged    = conv_q;
    assign bus.stop         = stop_q;
    assign bus.feature_loss = loss_q;

endmodule

// File: tb/tb_lk_iter_ctrl.sv
// Bench for lk_iter_ctrl: directed termination cases plus randomized features against a reference model.
// Latency: checks start->fetch, d_valid->fetch/done cycle counts.
// Backpressure: drives d_valid after a random wait in WAIT_D, with stray start pulses while busy.
module tb_lk_iter_ctrl;

    localparam int     D_BITS    = 32;
    localparam int     V_BITS    = 34;
    localparam int     ITER_BITS = 4;
    localparam int     K_MAX     = 8;
    localparam longint EPS_L     = 64'sd1 << 20;
    localparam longint LIM_L     = 64'sd15 << 26;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lk_iter_ctrl_if #(.D_BITS(D_BITS), .V_BITS(V_BITS), .ITER_BITS(ITER_BITS)) ifc ();

    lk_iter_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitors.
    int done_cnt   = 0;
    int fetch_cnt  = 0;
    int breset_cnt = 0;
    always @(posedge clk) begin
        if (ifc.done === 1'b1)      done_cnt++;
        if (ifc.fetch_req === 1'b1) fetch_cnt++;
        if (ifc.b_reset === 1'b1)   breset_cnt++;
    end

    // Per-pass stimulus.
    logic [31:0] p_dr [8];
    logic [31:0] p_dc [8];
    bit          p_vd [8];

    // Driver observations.
    bit obs_tmo;
    int obs_first;
    int obs_lat [8];

    typedef struct {
        longint vr;
        longint vc;
        int     iter;
        bit     conv;
        bit     stop;
        bit     loss;
        int     fetches;
    } exp_t;

    function automatic longint absl(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference: walk the passes with plain integer arithmetic.
    function automatic exp_t model(input longint gr, input longint gc);
        exp_t   e;
        longint d_r, d_c;
        e = '{default: 0};
        e.vr = gr;
        e.vc = gc;
        for (int i = 0; i < 8; i++) begin
            e.fetches++;
            if (!p_vd[i]) begin
                e.loss = 1'b1;
                break;
            end
            d_r = longint'($signed(p_dr[i]));
            d_c = longint'($signed(p_dc[i]));
            e.vr += d_r;
            e.vc += d_c;
            e.iter++;
            if (absl(e.vr) > LIM_L || absl(e.vc) > LIM_L) begin
                e.loss = 1'b1;
                break;
            end
            if (absl(d_r) < EPS_L && absl(d_c) < EPS_L) begin
                e.conv = 1'b1;
                break;
            end
            if (e.iter == K_MAX) begin
                e.stop = 1'b1;
                break;
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one feature through the protocol; returns at the sample point where done is seen.
    task automatic run_passes(input logic [V_BITS-1:0] gr, input logic [V_BITS-1:0] gc);
        int w;
        obs_tmo   = 1'b0;
        obs_first = -1;
        for (int i = 0; i < 8; i++) obs_lat[i] = -1;
        ifc.gr_in = gr;
        ifc.gc_in = gc;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.gr_in = {2'b01, $urandom()};
        ifc.gc_in = {2'b10, $urandom()};
        w = 1;
        while (ifc.fetch_req !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        if (ifc.fetch_req !== 1'b1) begin
            obs_tmo = 1'b1;
            return;
        end
        obs_first = w;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(1, 3)) begin
                tick();
                ifc.start = ($urandom_range(0, 3) == 0);
            end
            ifc.start     = 1'b0;
            ifc.d_valid   = 1'b1;
            ifc.dr        = p_dr[i];
            ifc.dc        = p_dc[i];
            ifc.valid_det = p_vd[i];
            tick();
            ifc.d_valid   = 1'b0;
            ifc.dr        = $urandom();
            ifc.dc        = $urandom();
            ifc.valid_det = 1'($urandom());
            w = 1;
            while (ifc.done !== 1'b1 && ifc.fetch_req !== 1'b1 && w < 10) begin
                tick();
                w++;
            end
            obs_lat[i] = w;
            if (ifc.done === 1'b1) return;
            if (ifc.fetch_req !== 1'b1) begin
                obs_tmo = 1'b1;
                return;
            end
        end
        obs_tmo = 1'b1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        ifc.start     = 1'b0;
        ifc.gr_in     = '0;
        ifc.gc_in     = '0;
        ifc.d_valid   = 1'b0;
        ifc.dr        = '0;
        ifc.dc        = '0;
        ifc.valid_det = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({ifc.busy, ifc.done, ifc.converged, ifc.stop, ifc.feature_loss, ifc.fetch_req, ifc.b_reset} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {ifc.busy, ifc.done, ifc.converged, ifc.stop, ifc.feature_loss, ifc.fetch_req, ifc.b_reset});
        end
        n_checks++;
        if ({ifc.vr, ifc.vc, ifc.iter_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: vr=%h vc=%h iter=%0d want all 0", ifc.vr, ifc.vc, ifc.iter_count);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (ifc.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b want 0", ifc.busy);
        end
    endtask

    task automatic test_converge();
        int f0;
        p_dr[0] = 32'h0200_0000; p_dc[0] = 32'hFF00_0000; p_vd[0] = 1'b1;
        p_dr[1] = 32'h0004_0000; p_dc[1] = 32'h0004_0000; p_vd[1] = 1'b1;
        for (int i = 2; i < 8; i++) begin p_dr[i] = '0; p_dc[i] = '0; p_vd[i] = 1'b1; end
        f0 = breset_cnt;
        run_passes('0, '0);
        n_checks++;
        if (obs_tmo || ifc.done !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_done: timeout=%0d done=%b want done", obs_tmo, ifc.done);
        end
        n_checks++;
        if ({ifc.converged, ifc.stop, ifc.feature_loss} !== 3'b100) begin
            n_fail++;
            $display("FAIL t1_flags: got %b want 100", {ifc.converged, ifc.stop, ifc.feature_loss});
        end
        n_checks++;
        if (ifc.iter_count !== 4'd2) begin
            n_fail++;
            $display("FAIL t1_iter: got %0d want 2", ifc.iter_count);
        end
        n_checks++;
        if (ifc.vr !== 34'h0_0204_0000 || ifc.vc !== 34'h3_FF04_0000) begin
            n_fail++;
            $display("FAIL t1_v: vr=%h vc=%h want 002040000 3ff040000", ifc.vr, ifc.vc);
        end
        n_checks++;
        if (obs_first !== 1 || obs_lat[0] !== 3 || obs_lat[1] !== 3) begin
            n_fail++;
            $display("FAIL t1_lat: start->fetch=%0d dv->fetch=%0d dv->done=%0d want 1 3 3",
                     obs_first, obs_lat[0], obs_lat[1]);
        end
        n_checks++;
        if (breset_cnt - f0 !== 2) begin
            n_fail++;
            $display("FAIL t1_breset: got %0d pulses want 2", breset_cnt - f0);
        end
        tick();
        n_checks++;
        if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.vr !== 34'h0_0204_0000 || ifc.converged !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_hold: done=%b busy=%b vr=%h conv=%b want 0 0 002040000 1",
                     ifc.done, ifc.busy, ifc.vr, ifc.converged);
        end
    endtask

    task automatic test_iter_limit();
        int f0;
        for (int i = 0; i < 8; i++) begin p_dr[i] = 32'h0100_0000; p_dc[i] = 32'h0100_0000; p_vd[i] = 1'b1; end
        f0 = fetch_cnt;
        run_passes('0, '0);
        n_checks++;
        if (obs_tmo || fetch_cnt - f0 !== 8) begin
            n_fail++;
            $display("FAIL t2_fetch: timeout=%0d fetches=%0d want 8", obs_tmo, fetch_cnt - f0);
        end
        n_checks++;
        if ({ifc.converged, ifc.stop, ifc.feature_loss} !== 3'b010 || ifc.iter_count !== 4'd8) begin
            n_fail++;
            $display("FAIL t2_stop: flags=%b iter=%0d want 010 8",
                     {ifc.converged, ifc.stop, ifc.feature_loss}, ifc.iter_count);
        end
        n_checks++;
        if (ifc.vr !== 34'h0_0800_0000 || ifc.vc !== 34'h0_0800_0000) begin
            n_fail++;
            $display("FAIL t2_v: vr=%h vc=%h want 008000000", ifc.vr, ifc.vc);
        end
        tick();
    endtask

    task automatic test_det_loss();
        logic [V_BITS-1:0] g_r, g_c;
        g_r = 34'h0_1234_5678;
        g_c = 34'h3_F00A_BCDE;
        p_dr[0] = 32'h0040_0000; p_dc[0] = 32'h0040_0000; p_vd[0] = 1'b0;
        run_passes(g_r, g_c);
        n_checks++;
        if (obs_tmo || {ifc.converged, ifc.stop, ifc.feature_loss} !== 3'b001 || ifc.iter_count !== 4'd0) begin
            n_fail++;
            $display("FAIL t3_loss: timeout=%0d flags=%b iter=%0d want 001 0",
                     obs_tmo, {ifc.converged, ifc.stop, ifc.feature_loss}, ifc.iter_count);
        end
        n_checks++;
        if (ifc.vr !== g_r || ifc.vc !== g_c) begin
            n_fail++;
            $display("FAIL t3_v: vr=%h vc=%h want %h %h", ifc.vr, ifc.vc, g_r, g_c);
        end
        n_checks++;
        if (obs_lat[0] !== 2) begin
            n_fail++;
            $display("FAIL t3_lat: dv->done=%0d want 2", obs_lat[0]);
        end
        tick();
    endtask

    task automatic test_vlimit();
        p_dr[0] = 32'h0600_0000; p_dc[0] = 32'h0; p_vd[0] = 1'b1;
        run_passes(34'h0_3800_0000, '0);
        n_checks++;
        if (obs_tmo || {ifc.converged, ifc.stop, ifc.feature_loss} !== 3'b001 || ifc.iter_count !== 4'd1) begin
            n_fail++;
            $display("FAIL t4_loss: timeout=%0d flags=%b iter=%0d want 001 1",
                     obs_tmo, {ifc.converged, ifc.stop, ifc.feature_loss}, ifc.iter_count);
        end
        n_checks++;
        if (ifc.vr !== 34'h0_3E00_0000) begin
            n_fail++;
            $display("FAIL t4_v: vr=%h want 03e000000", ifc.vr);
        end
        tick();
        // Exactly 15.0 px on both axes is still inside the limit.
        p_dr[0] = 32'h0100_0000; p_dc[0] = 32'hFF00_0000; p_vd[0] = 1'b1;
        p_dr[1] = 32'h0;         p_dc[1] = 32'h0;         p_vd[1] = 1'b1;
        run_passes(34'h0_3B00_0000, 34'h3_C500_0000);
        n_checks++;
        if (obs_tmo || {ifc.converged, ifc.stop, ifc.feature_loss} !== 3'b100 || ifc.iter_count !== 4'd2) begin
            n_fail++;
            $display("FAIL edge_lim: timeout=%0d flags=%b iter=%0d want 100 2",
                     obs_tmo, {ifc.converged, ifc.stop, ifc.feature_loss}, ifc.iter_count);
        end
        n_checks++;
        if (ifc.vr !== 34'h0_3C00_0000 || ifc.vc !== 34'h3_C400_0000) begin
            n_fail++;
            $display("FAIL edge_lim_v: vr=%h vc=%h want 03c000000 3c4000000", ifc.vr, ifc.vc);
        end
        tick();
    endtask

    task automatic test_eps_edge();
        // |dr| == EPS is not small; |d| == EPS-1 on both axes is.
        p_dr[0] = 32'h0010_0000; p_dc[0] = 32'h0;         p_vd[0] = 1'b1;
        p_dr[1] = 32'hFFF0_0001; p_dc[1] = 32'hFFF0_0001; p_vd[1] = 1'b1;
        run_passes('0, '0);
        n_checks++;
        if (obs_tmo || {ifc.converged, ifc.stop, ifc.feature_loss} !== 3'b100 || ifc.iter_count !== 4'd2) begin
            n_fail++;
            $display("FAIL eps_edge: timeout=%0d flags=%b iter=%0d want 100 2",
                     obs_tmo, {ifc.converged, ifc.stop, ifc.feature_loss}, ifc.iter_count);
        end
        tick();
    endtask

    task automatic test_most_neg();
        p_dr[0] = 32'h8000_0000; p_dc[0] = 32'h0; p_vd[0] = 1'b1;
        run_passes('0, '0);
        n_checks++;
        if (obs_tmo || {ifc.converged, ifc.stop, ifc.feature_loss} !== 3'b001) begin
            n_fail++;
            $display("FAIL t5_loss: timeout=%0d flags=%b want 001",
                     obs_tmo, {ifc.converged, ifc.stop, ifc.feature_loss});
        end
        n_checks++;
        if (ifc.vr !== 34'h3_8000_0000) begin
            n_fail++;
            $display("FAIL t5_v: vr=%h want 380000000", ifc.vr);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int d0;
        int w;
        ifc.gr_in = 34'h0_0123_4567;
        ifc.gc_in = 34'h0_0765_4321;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        tick();
        tick();
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({ifc.busy, ifc.done, ifc.converged, ifc.stop, ifc.feature_loss, ifc.fetch_req, ifc.b_reset} !== 7'b0 ||
            {ifc.vr, ifc.vc, ifc.iter_count} !== '0) begin
            n_fail++;
            $display("FAIL t6_async: busy=%b vr=%h vc=%h iter=%0d want all 0",
                     ifc.busy, ifc.vr, ifc.vc, ifc.iter_count);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        // d_valid while idle must do nothing.
        ifc.d_valid   = 1'b1;
        ifc.valid_det = 1'b0;
        tick();
        ifc.d_valid   = 1'b0;
        tick();
        tick();
        n_checks++;
        if (done_cnt !== d0 || ifc.busy !== 1'b0 || ifc.feature_loss !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_idle: done_pulses=%0d busy=%b loss=%b want 0 0 0",
                     done_cnt - d0, ifc.busy, ifc.feature_loss);
        end
        // start while busy (in WAIT_D) must not reload the guess.
        ifc.gr_in = 34'h0_0111_0000;
        ifc.gc_in = 34'h0_0222_0000;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        tick();
        ifc.gr_in = 34'h0_0999_0000;
        ifc.start = 1'b1;
        tick();
        ifc.start     = 1'b0;
        ifc.d_valid   = 1'b1;
        ifc.valid_det = 1'b1;
        ifc.dr        = '0;
        ifc.dc        = '0;
        tick();
        ifc.d_valid = 1'b0;
        w = 0;
        while (ifc.done !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        n_checks++;
        if (ifc.done !== 1'b1 || ifc.vr !== 34'h0_0111_0000 || ifc.converged !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_busy_start: done=%b vr=%h conv=%b want 1 001110000 1",
                     ifc.done, ifc.vr, ifc.converged);
        end
        tick();
    endtask

    task automatic test_random();
        exp_t   e;
        longint g_r, g_c;
        int     f0, kind;
        for (int n = 0; n < 40; n++) begin
            g_r = longint'($urandom_range(0, 32'h8000_0000)) - 64'sh4000_0000;
            g_c = longint'($urandom_range(0, 32'h8000_0000)) - 64'sh4000_0000;
            for (int i = 0; i < 8; i++) begin
                for (int a = 0; a < 2; a++) begin
                    kind = $urandom_range(0, 9);
                    if (kind < 2)       p_dr[i] = 32'($urandom_range(0, 32'h001F_FFFE)) - 32'h000F_FFFF;
                    else if (kind < 8)  p_dr[i] = 32'($urandom_range(0, 32'h0800_0000)) - 32'h0400_0000;
                    else if (kind == 8) p_dr[i] = $urandom();
                    else                p_dr[i] = 32'h8000_0000;
                    if (a == 0) p_dc[i] = p_dr[i];
                end
                p_vd[i] = ($urandom_range(0, 11) != 0);
            end
            e  = model(g_r, g_c);
            f0 = fetch_cnt;
            run_passes(V_BITS'(g_r), V_BITS'(g_c));
            n_checks++;
            if (obs_tmo || ifc.done !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd%0d_done: timeout=%0d done=%b", n, obs_tmo, ifc.done);
            end
            n_checks++;
            if ({ifc.converged, ifc.stop, ifc.feature_loss} !== {e.conv, e.stop, e.loss}) begin
                n_fail++;
                $display("FAIL rnd%0d_flags: got %b want %b", n,
                         {ifc.converged, ifc.stop, ifc.feature_loss}, {e.conv, e.stop, e.loss});
            end
            n_checks++;
            if (ifc.iter_count !== ITER_BITS'(e.iter) || fetch_cnt - f0 !== e.fetches) begin
                n_fail++;
                $display("FAIL rnd%0d_iter: iter=%0d fetches=%0d want %0d %0d", n,
                         ifc.iter_count, fetch_cnt - f0, e.iter, e.fetches);
            end
            n_checks++;
            if (ifc.vr !== V_BITS'(e.vr) || ifc.vc !== V_BITS'(e.vc)) begin
                n_fail++;
                $display("FAIL rnd%0d_v: vr=%h vc=%h want %h %h", n,
                         ifc.vr, ifc.vc, V_BITS'(e.vr), V_BITS'(e.vc));
            end
            for (int i = 0; i < e.fetches; i++) begin
                n_checks++;
                if (obs_lat[i] !== (p_vd[i] ? 3 : 2)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_lat%0d: got %0d want %0d", n, i, obs_lat[i], p_vd[i] ? 3 : 2);
                end
            end
            tick();
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_converge();
        test_iter_limit();
        test_det_loss();
        test_vlimit();
        test_eps_edge();
        test_most_neg();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
